// File: rtl/accum_drain_pkg.sv
// Shared requant constants for the accumulator drain and the activation/weight loaders.
// Saturation bounds are derived from the output width so every user clamps identically.
package accum_drain_pkg;

    localparam int ODATAW_DEF = 8;
    localparam int AFULL_DEF  = 12;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(ODATAW_DEF);
    localparam longint SAT_MIN = sat_min(ODATAW_DEF);

endpackage

// File: rtl/fifo_sync.sv
// Synchronous show-ahead FIFO; head visible on rd_dat_o whenever not empty, zero otherwise.
// Latency: write visible one cycle after push. A push on full is ignored unless a pop shares the cycle.
module fifo_sync #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int ADDRW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     wr_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     rd_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [ADDRW:0]   count_o
);

    localparam logic [ADDRW:0]   CNT_ONE  = (ADDRW + 1)'(1);
    localparam logic [ADDRW:0]   CNT_FULL = (ADDRW + 1)'(DEPTH);
    localparam logic [ADDRW-1:0] PTR_ONE  = ADDRW'(1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [ADDRW-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDRW:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_FULL);
    assign count_o  = count_q;
    assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/accum_drain.sv
// Requantizes accumulator sums (ReLU, rounding shift, saturate) into a show-ahead output FIFO.
// Latency: 3 cycles input to o_valid on an empty FIFO. No input backpressure; o_afull warns upstream, drops set o_overflow.
module accum_drain
    import accum_drain_pkg::*;
#(
    parameter int IDATAW = 32,
    parameter int ODATAW = ODATAW_DEF,
    parameter int SHIFTW = 5,
    parameter int DEPTH  = 16,
    parameter int ADDRW  = 4,
    parameter int AFULL  = AFULL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [IDATAW-1:0] i_data,
    input  logic              i_relu,
    input  logic [SHIFTW-1:0] i_shift,
    output logic              o_afull,
    output logic              o_overflow,
    output logic              o_valid,
    output logic [ODATAW-1:0] o_data,
    input  logic              i_ready
);

    localparam int             XW        = IDATAW + 1;
    localparam longint         SAT_HI    = sat_max(ODATAW);
    localparam longint         SAT_LO    = sat_min(ODATAW);
    localparam logic [ADDRW:0] CNT_ONE   = (ADDRW + 1)'(1);
    localparam logic [ADDRW:0] CNT_AFULL = (ADDRW + 1)'(AFULL);

    logic signed [XW-1:0] x, sum, s1_d, s1_q;
    logic [XW-1:0]        bias;
    logic                 s1_vld_q;
    logic [ODATAW-1:0]    s2_d, s2_q;
    logic                 s2_vld_q;

    logic                 pop, push_ok, drop;
    logic                 fifo_full, fifo_empty;
    logic [ADDRW:0]       fifo_count, occ_d;
    logic                 afull_q, ovf_q;

    // One extra bit keeps the rounding bias from overflowing the largest positive sum.
    always_comb begin
        x    = (i_relu && i_data[IDATAW-1]) ? '0 : $signed({i_data[IDATAW-1], i_data});
        bias = '0;
        if (i_shift != '0) begin
            bias = XW'(1) << (i_shift - SHIFTW'(1));
        end
        sum  = x + $signed(bias);
        s1_d = sum >>> i_shift;
    end

    always_comb begin
        s2_d = s1_q[ODATAW-1:0];
        if (longint'(s1_q) > SAT_HI) begin
            s2_d = ODATAW'(SAT_HI);
        end else if (longint'(s1_q) < SAT_LO) begin
            s2_d = ODATAW'(SAT_LO);
        end
    end

    assign pop     = o_valid && i_ready;
    assign push_ok = s2_vld_q && (!fifo_full || pop);
    assign drop    = s2_vld_q && fifo_full && !pop;

    always_comb begin
        occ_d = fifo_count;
        if (push_ok && !pop) begin
            occ_d = fifo_count + CNT_ONE;
        end else if (!push_ok && pop) begin
            occ_d = fifo_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            s1_vld_q <= i_valid;
            s1_q     <= s1_d;
            s2_vld_q <= s1_vld_q;
            s2_q     <= s2_d;
            afull_q  <= (occ_d >= CNT_AFULL);
            ovf_q    <= ovf_q | drop;
        end
    end

    fifo_sync #(
        .W     (ODATAW),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (s2_vld_q),
        .wr_dat_i (s2_q),
        .pop_i    (pop),
        .rd_dat_o (o_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign o_valid    = !fifo_empty;
    assign o_afull    = afull_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_accum_drain.sv
// Bench for accum_drain: directed scenarios plus a long randomized run against a queue-based model.
module tb_accum_drain;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_relu;
    logic [4:0]  i_shift;
    logic        o_afull;
    logic        o_overflow;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        i_ready;

    int tests = 0;
    int fails = 0;

    accum_drain dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_relu     (i_relu),
        .i_shift    (i_shift),
        .o_afull    (o_afull),
        .o_overflow (o_overflow),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requant rule: ReLU, add half of the divisor, floor-divide by 2^sh, clamp to int8.
    function automatic int ref_q(input int d, input bit relu, input int sh);
        longint x;
        longint r;
        x = (relu && d < 0) ? 0 : longint'(d);
        if (sh > 0) x = x + (longint'(1) << (sh - 1));
        r = x >>> sh;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    // Cycle-level reference: two-slot delay line feeding a 16-deep queue.
    int mq[$];
    bit mp0_vld = 0, mp1_vld = 0;
    int mp0_dat = 0, mp1_dat = 0;
    bit movf = 0, mafull = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mp0_vld <= 1'b0;
            mp1_vld <= 1'b0;
            movf    <= 1'b0;
            mafull  <= 1'b0;
        end else begin
            if (mq.size() > 0 && i_ready) mq.delete(0);
            if (mp1_vld) begin
                if (mq.size() < 16) mq.push_back(mp1_dat);
                else                movf <= 1'b1;
            end
            mafull  <= (mq.size() >= 12);
            mp1_vld <= mp0_vld;
            mp1_dat <= mp0_dat;
            mp0_vld <= i_valid;
            mp0_dat <= ref_q($signed(i_data), i_relu, int'(i_shift));
        end
    end

    task automatic drive(input bit v, input int d, input bit relu, input int sh);
        i_valid = v;
        i_data  = d;
        i_relu  = relu;
        i_shift = 5'(sh);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_ready = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        tests++; if (o_data !== 8'd0) begin fails++; $display("FAIL reset_data: got %0d want 0", o_data); end
        tests++; if (o_afull !== 1'b0) begin fails++; $display("FAIL reset_afull: got %b want 0", o_afull); end
        tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        @(negedge clk);
        i_ready = 1'b1;
        drive(1, 1000, 0, 4);
        @(negedge clk);
        i_valid = 1'b0;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL lat_edge1: o_valid got %b want 0", o_valid); end
        @(negedge clk);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL lat_edge2: o_valid got %b want 0", o_valid); end
        @(negedge clk);
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL lat_edge3: o_valid got %b want 1", o_valid); end
        tests++; if ($signed(o_data) !== 8'sd63) begin fails++; $display("FAIL lat_data: got %0d want 63", $signed(o_data)); end
        @(negedge clk);
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL lat_popped: o_valid got %b want 0", o_valid); end
    endtask

    task automatic test_requant_table();
        int td [7] = '{-300, -300, 200, 6, 5, -6, -7};
        bit tr [7] = '{1, 0, 0, 0, 0, 0, 0};
        int ts [7] = '{0, 0, 0, 2, 2, 2, 2};
        int te [7] = '{0, -128, 127, 2, 1, -1, -2};
        i_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1, td[i], tr[i], ts[i]);
            @(negedge clk);
            i_valid = 1'b0;
            repeat (2) @(negedge clk);
            tests++;
            if (o_valid !== 1'b1 || int'($signed(o_data)) !== te[i]) begin
                fails++;
                $display("FAIL requant[%0d]: valid=%b data=%0d want valid=1 data=%0d", i, o_valid, $signed(o_data), te[i]);
            end
            i_ready = 1'b1;
            @(negedge clk);
            i_ready = 1'b0;
        end
    endtask

    task automatic test_fill_overflow();
        i_ready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            tests++; if (o_afull !== (mq.size() >= 12)) begin fails++; $display("FAIL fill_afull[%0d]: got %b want %b", k, o_afull, mq.size() >= 12); end
            drive(1, k * 16, 0, 4);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            tests++; if (o_afull !== (mq.size() >= 12)) begin fails++; $display("FAIL fill_afull_tail[%0d]: got %b want %b", k, o_afull, mq.size() >= 12); end
        end
        tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf: got %b want 1", o_overflow); end
        tests++; if (o_afull !== 1'b1) begin fails++; $display("FAIL fill_afull_full: got %b want 1", o_afull); end
        i_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tests++;
            if (o_valid !== 1'b1 || int'($signed(o_data)) !== k) begin
                fails++;
                $display("FAIL drain[%0d]: valid=%b data=%0d want valid=1 data=%0d", k, o_valid, $signed(o_data), k);
            end
            @(negedge clk);
        end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b want 0", o_valid); end
        tests++; if (o_afull !== 1'b0) begin fails++; $display("FAIL drain_afull: got %b want 0", o_afull); end
        tests++; if (o_overflow !== 1'b1) begin fails++; $display("FAIL drain_ovf_sticky: got %b want 1", o_overflow); end
        i_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        bit stable;
        pulse_reset();
        i_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            drive(1, k * 16, 0, 4);
            @(negedge clk);
        end
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        stable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (o_valid !== 1'b1 || int'($signed(o_data)) !== 1) stable = 1'b0;
            @(negedge clk);
        end
        tests++; if (stable !== 1'b1) begin fails++; $display("FAIL stall_hold: valid=%b data=%0d want valid=1 data=1", o_valid, $signed(o_data)); end
        drive(1, 17 * 16, 0, 4);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL pushpop_ovf: got %b want 0", o_overflow); end
        tests++; if (int'($signed(o_data)) !== 2) begin fails++; $display("FAIL pushpop_head: got %0d want 2", $signed(o_data)); end
        tests++; if (o_afull !== 1'b1) begin fails++; $display("FAIL pushpop_afull: got %b want 1", o_afull); end
        i_ready = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            tests++;
            if (o_valid !== 1'b1 || int'($signed(o_data)) !== k) begin
                fails++;
                $display("FAIL pushpop_drain[%0d]: valid=%b data=%0d want valid=1 data=%0d", k, o_valid, $signed(o_data), k);
            end
            @(negedge clk);
        end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL pushpop_empty: got %b want 0", o_valid); end
        i_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bit quiet;
        i_ready = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            drive(1, j * 16, 0, 4);
            if (j == 8) begin
                tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre: o_valid got %b want 1", o_valid); end
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
        tests++; if (o_data !== 8'd0) begin fails++; $display("FAIL midrst_data: got %0d want 0", o_data); end
        tests++; if (o_afull !== 1'b0) begin fails++; $display("FAIL midrst_afull: got %b want 0", o_afull); end
        i_ready = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) quiet = 1'b0;
        end
        tests++; if (quiet !== 1'b1) begin fails++; $display("FAIL midrst_stale: stale output after reset, want none"); end
        i_ready = 1'b0;
    endtask

    task automatic test_random();
        bit relu;
        int sh;
        int rdy_pct;
        int d;
        pulse_reset();
        relu = 1'b0;
        sh = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            tests++;
            if (o_valid !== (mq.size() != 0) || o_afull !== mafull || o_overflow !== movf ||
                (mq.size() != 0 && int'($signed(o_data)) !== mq[0])) begin
                fails++;
                $display("FAIL random[%0d]: valid=%b afull=%b ovf=%b data=%0d want valid=%b afull=%b ovf=%b data=%0d",
                         cyc, o_valid, o_afull, o_overflow, $signed(o_data), mq.size() != 0, mafull, movf,
                         (mq.size() != 0) ? mq[0] : 0);
            end
            if (cyc % 200 == 0) begin
                relu = 1'($urandom_range(0, 1));
                sh   = int'($urandom_range(0, 31));
            end
            rdy_pct = ((cyc / 500) % 2 == 1) ? 85 : 30;
            d = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
            drive($urandom_range(0, 99) < 60, d, relu, sh);
            i_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        i_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_requant_table();
        test_fill_overflow();
        test_full_push_pop();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
